br_pred_update_queue: RTL and testbench

- Writer side of the pattern history table: tracks in-flight conditional branches from fetch (index plus predicted direction) and, as each branch resolves in execute, drives the PHT update port and raises a mispredict pulse.
- Sits between fetch (push side) and execute (resolve side) in the in-order pipeline.
- Its outputs connect directly to the PHT's update_pht, pht_w_idx and br_en inputs.

---
 rtl/br_pred_update_queue_pkg.sv | 20 ++
 rtl/br_pred_update_queue_if.sv | 51 +++++
 rtl/br_q_fifo.sv | 52 +++++
 rtl/br_pred_update_queue.sv | 102 ++++++++++
 tb/tb_br_pred_update_queue.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/br_pred_update_queue_pkg.sv
// Shared types and constants for the branch-predictor update queue.
//   q_state_t  : queue control state (NORMAL / RECOVER)
//   OP_BR      : RV32I conditional-branch opcode
//   sat_add32  : 32-bit saturating add used by the optional statistics counters
package br_pred_update_queue_pkg;

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } q_state_t;

    localparam logic [6:0] OP_BR = 7'b1100011;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/br_pred_update_queue_if.sv
// Handshake/bus bundle between fetch, execute, the update queue and the PHT.
//   push_*      : fetch-side enqueue of predicted branches
//   res_*       : execute-side resolution of the oldest branch
//   update_pht, pht_w_idx, br_en : PHT write port
//   mis_predict, occupancy, underflow_err : status
// Optional macro BR_PRED_STATS_EN adds stat_branches/stat_mispred/stat_flushed.
// slave modport is the queue; master modport is its environment.
interface br_pred_update_queue_if #(
    parameter int PHTIDX = 4,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              push_valid;
    logic              push_ready;
    logic [6:0]        push_opcode;
    logic [PHTIDX-1:0] push_idx;
    logic              push_pred;
    logic              res_valid;
    logic              res_br_en;
    logic              update_pht;
    logic [PHTIDX-1:0] pht_w_idx;
    logic              br_en;
    logic              mis_predict;
    logic [CW-1:0]     occupancy;
    logic              underflow_err;
`ifdef BR_PRED_STATS_EN
    logic [31:0]       stat_branches;
    logic [31:0]       stat_mispred;
    logic [31:0]       stat_flushed;
`endif

    modport slave (
        input  push_valid, push_opcode, push_idx, push_pred, res_valid, res_br_en,
        output push_ready, update_pht, pht_w_idx, br_en, mis_predict, occupancy,
               underflow_err
`ifdef BR_PRED_STATS_EN
        , output stat_branches, stat_mispred, stat_flushed
`endif
    );

    modport master (
        output push_valid, push_opcode, push_idx, push_pred, res_valid, res_br_en,
        input  push_ready, update_pht, pht_w_idx, br_en, mis_predict, occupancy,
               underflow_err
`ifdef BR_PRED_STATS_EN
        , input stat_branches, stat_mispred, stat_flushed
`endif
    );

endinterface

// File: rtl/br_q_fifo.sv
// Circular buffer of in-flight branch entries.
//   clk, rst (sync, active-low)
//   push/push_data : enqueue at tail (caller guarantees not full)
//   pop            : dequeue head (caller guarantees not empty)
//   flush          : discard everything, pointers and count back to zero
//   head_data      : entry at head
//   count          : valid entries, 0..DEPTH
module br_q_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [W-1:0]                 head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;

    assign head_data = mem[head_ptr];

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (rst && push && !flush) begin
            mem[tail_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/br_pred_update_queue.sv
// Branch predictor update queue: holds {idx, pred} of in-flight conditional
// branches and, one cycle after each resolves, drives the PHT write port and
// a mis_predict pulse. A mispredict flushes all entries and enters a one-cycle
// RECOVER state during which pushes and resolves are ignored.
//   clk, rst (sync, active-low)
//   bus : br_pred_update_queue_if.slave (push, resolve, PHT update, status)
// Optional macro BR_PRED_STATS_EN enables saturating 32-bit statistics.
module br_pred_update_queue
    import br_pred_update_queue_pkg::*;
#(
    parameter int PHTIDX = 4,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    br_pred_update_queue_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PHTIDX-1:0] idx;
        logic              pred;
    } br_q_entry_t;

    q_state_t      state;
    logic [CW-1:0] count;
    br_q_entry_t   head;
    br_q_entry_t   push_entry;
    logic          is_empty;
    logic          is_full;
    logic          res_fire;
    logic          mispredict;
    logic          push_fire;

    assign is_empty   = (count == '0);
    assign is_full    = (count == CW'(DEPTH));
    assign bus.push_ready = (state == NORMAL) && !is_full;
    assign res_fire   = bus.res_valid && (state == NORMAL) && !is_empty;
    assign mispredict = res_fire && (head.pred != bus.res_br_en);
    // A push coinciding with a mispredict is on the wrong path and is dropped.
    assign push_fire  = bus.push_valid && bus.push_ready && (bus.push_opcode == OP_BR)
                        && !mispredict;
    assign push_entry = '{idx: bus.push_idx, pred: bus.push_pred};
    assign bus.occupancy = count;

    br_q_fifo #(
        .W     ($bits(br_q_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_fire),
        .push_data (push_entry),
        .pop       (res_fire),
        .flush     (mispredict),
        .head_data (head),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= NORMAL;
            bus.update_pht    <= 1'b0;
            bus.mis_predict   <= 1'b0;
            bus.pht_w_idx     <= '0;
            bus.br_en         <= 1'b0;
            bus.underflow_err <= 1'b0;
        end else begin
            bus.update_pht  <= res_fire;
            bus.mis_predict <= mispredict;
            if (res_fire) begin
                bus.pht_w_idx <= head.idx;
                bus.br_en     <= bus.res_br_en;
            end
            if (bus.res_valid && (state == NORMAL) && is_empty) begin
                bus.underflow_err <= 1'b1;
            end
            unique case (state)
                NORMAL:  if (mispredict) state <= RECOVER;
                RECOVER: state <= NORMAL;
            endcase
        end
    end

`ifdef BR_PRED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.stat_branches <= '0;
            bus.stat_mispred  <= '0;
            bus.stat_flushed  <= '0;
        end else begin
            if (res_fire)   bus.stat_branches <= sat_add32(bus.stat_branches, 32'd1);
            if (mispredict) begin
                bus.stat_mispred <= sat_add32(bus.stat_mispred, 32'd1);
                // The resolving head is not counted as flushed.
                bus.stat_flushed <= sat_add32(bus.stat_flushed, 32'(count) - 32'd1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_br_pred_update_queue.sv
module tb_br_pred_update_queue;
    import br_pred_update_queue_pkg::*;

    typedef struct {
        logic [3:0] idx;
        logic       br_en;
        logic       mis;
    } exp_t;

    typedef struct {
        logic [3:0] idx;
        logic       pred;
    } ent_t;

    exp_t sb[$];
    ent_t mq[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    br_pred_update_queue_if #(.PHTIDX(4), .DEPTH(4)) bus ();

    br_pred_update_queue #(.PHTIDX(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endtask

    // Hold one set of inputs for exactly one rising edge, return #1 after it.
    task automatic drive(input logic pv, input logic [6:0] op, input logic [3:0] idx,
                         input logic pred, input logic rv, input logic rb);
        bus.push_valid  = pv;
        bus.push_opcode = op;
        bus.push_idx    = idx;
        bus.push_pred   = pred;
        bus.res_valid   = rv;
        bus.res_br_en   = rb;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_br(input logic [3:0] idx, input logic pred);
        drive(1'b1, OP_BR, idx, pred, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic rb, input logic [3:0] e_idx, input logic e_mis);
        sb.push_back('{idx: e_idx, br_en: rb, mis: e_mis});
        drive(1'b0, 7'd0, 4'd0, 1'b0, 1'b1, rb);
    endtask

    // Monitor: every PHT update must match the oldest scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.update_pht === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_update: got idx %0h expected no update", bus.pht_w_idx);
                end else begin
                    e = sb.pop_front();
                    check("upd_idx",   32'(bus.pht_w_idx),   32'(e.idx));
                    check("upd_br_en", 32'(bus.br_en),       32'(e.br_en));
                    check("upd_mis",   32'(bus.mis_predict), 32'(e.mis));
                end
            end else if (bus.mis_predict === 1'b1) begin
                n_checks++;
                $display("FAIL lone_mispredict: got mis_predict 1 expected 0 without update");
            end
        end
    end

    initial begin
        bus.push_valid = 1'b0; bus.push_opcode = '0; bus.push_idx = '0;
        bus.push_pred = 1'b0; bus.res_valid = 1'b0; bus.res_br_en = 1'b0;

        // Reset state
        rst = 1'b0;
        idle(); idle();
        check("rst_update",    32'(bus.update_pht),    32'd0);
        check("rst_mis",       32'(bus.mis_predict),   32'd0);
        check("rst_idx",       32'(bus.pht_w_idx),     32'd0);
        check("rst_br_en",     32'(bus.br_en),         32'd0);
        check("rst_occ",       32'(bus.occupancy),     32'd0);
        check("rst_underflow", 32'(bus.underflow_err), 32'd0);
        check("rst_ready",     32'(bus.push_ready),    32'd1);
        rst = 1'b1;

        // Single branch, correct prediction
        push_br(4'h3, 1'b1);
        check("t1_occ1", 32'(bus.occupancy), 32'd1);
        resolve(1'b1, 4'h3, 1'b0);
        check("t1_occ0", 32'(bus.occupancy), 32'd0);
        idle();
        check("t1_upd_low",  32'(bus.update_pht), 32'd0);
        check("t1_idx_hold", 32'(bus.pht_w_idx),  32'd3);
        check("t1_br_hold",  32'(bus.br_en),      32'd1);

        // Fill, overflow attempt, in-order drain
        for (int i = 1; i <= 4; i++) push_br(4'(i), 1'b1);
        check("fill_occ",   32'(bus.occupancy),  32'd4);
        check("fill_ready", 32'(bus.push_ready), 32'd0);
        push_br(4'h9, 1'b1);
        check("fill_5th_occ", 32'(bus.occupancy), 32'd4);
        for (int i = 1; i <= 4; i++) resolve(1'b1, 4'(i), 1'b0);
        check("drain_occ", 32'(bus.occupancy), 32'd0);

        // Mispredict flush with a wrong-path push in the resolve cycle
        push_br(4'h5, 1'b0);
        push_br(4'h6, 1'b1);
        push_br(4'h7, 1'b1);
        check("mp_occ3", 32'(bus.occupancy), 32'd3);
        sb.push_back('{idx: 4'h5, br_en: 1'b1, mis: 1'b1});
        drive(1'b1, OP_BR, 4'h8, 1'b1, 1'b1, 1'b1);
        check("mp_occ0",  32'(bus.occupancy),   32'd0);
        check("mp_ready", 32'(bus.push_ready),  32'd0);
        check("mp_pulse", 32'(bus.mis_predict), 32'd1);
        // RECOVER cycle: push and resolve both ignored, no underflow
        drive(1'b1, OP_BR, 4'hA, 1'b1, 1'b1, 1'b0);
        check("rec_ready",     32'(bus.push_ready),    32'd1);
        check("rec_occ",       32'(bus.occupancy),     32'd0);
        check("rec_underflow", 32'(bus.underflow_err), 32'd0);
        check("rec_mis_low",   32'(bus.mis_predict),   32'd0);

        // Opcode filtering and underflow
        drive(1'b1, 7'b0110011, 4'h2, 1'b1, 1'b0, 1'b0);
        check("filt_occ", 32'(bus.occupancy), 32'd0);
        drive(1'b0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        check("uf_set",    32'(bus.underflow_err), 32'd1);
        check("uf_no_upd", 32'(bus.update_pht),    32'd0);
        idle();
        check("uf_sticky", 32'(bus.underflow_err), 32'd1);

        // Concurrent push/resolve at occupancy 2 across pointer wrap
        mq.push_back('{idx: 4'h1, pred: 1'b1}); push_br(4'h1, 1'b1);
        mq.push_back('{idx: 4'h2, pred: 1'b0}); push_br(4'h2, 1'b0);
        check("wrap_occ_start", 32'(bus.occupancy), 32'd2);
        for (int i = 0; i < 10; i++) begin
            ent_t h;
            ent_t n;
            h = mq.pop_front();
            n.idx  = 4'(3 + i);
            n.pred = 1'(i & 1);
            mq.push_back(n);
            sb.push_back('{idx: h.idx, br_en: h.pred, mis: 1'b0});
            drive(1'b1, OP_BR, n.idx, n.pred, 1'b1, h.pred);
            check("wrap_occ", 32'(bus.occupancy), 32'd2);
        end

        // Reset mid-stream with a resolve pending: no update may follow
        rst = 1'b0;
        drive(1'b0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        check("mrst_update",    32'(bus.update_pht),    32'd0);
        check("mrst_mis",       32'(bus.mis_predict),   32'd0);
        check("mrst_idx",       32'(bus.pht_w_idx),     32'd0);
        check("mrst_br_en",     32'(bus.br_en),         32'd0);
        check("mrst_occ",       32'(bus.occupancy),     32'd0);
        check("mrst_underflow", 32'(bus.underflow_err), 32'd0);
        rst = 1'b1;
        idle(); idle();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
